bus_lsu: RTL and testbench
==========================

# bus_lsu

Load/store unit that sits directly upstream of the system bus interconnect. It is the CPU's single data-side bus master. It converts one processor memory instruction into one bus transaction: byte-enable generation, write-data lane replication, read-data extraction with sign/zero extension, misalignment checking, and bus-error and timeout reporting. Its bus-side ports connect one-to-one to the interconnect's master entry.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 256: maximum number of cycles `bus_req` may stay high without `bus_ack`/`bus_error` before the access is aborted. Legal range is 2..65535.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- lsu_req  in  1  CPU requests a memory access. Held, with stable operands, while `lsu_stall`=1.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- lsu_unsigned  in  1  load zero-extends (1) or sign-extends (0).
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data, taken from the low bits.
- lsu_rdata  out  32  extended load result. Valid when `lsu_done`=1.
- lsu_stall  out  1  CPU must hold the current instruction.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_fault  out  2  valid with `lsu_done`: 0 ok, 1 misaligned/illegal size, 2 bus error, 3 timeout.
- bus_addr  out  32  word-aligned address ({lsu_addr[31:2],2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_req  out  1  bus request. Registered.
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables.
- bus_rdata  in  32  read data from the interconnect.
- bus_ack  in  1  transaction complete. May be combinational in the same cycle as `bus_req`.
- bus_error  in  1  unmapped address. Arrives registered, one cycle after `bus_req` is first seen.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE, `lsu_req`=0: stay in IDLE; all outputs low.
- IDLE, `lsu_req`=1, access misaligned or illegal:
  - Misaligned means word with addr[1:0]≠0, or half with addr[0]≠0; illegal means size 11.
  - Latch fault=1 and go to RESP.
  - No bus activity.
- IDLE, `lsu_req`=1, access legal: latch the following, then go to BUS.
  - `bus_addr`, `bus_we`, and the 2-bit byte offset.
  - size and `lsu_unsigned`.
  - `bus_be`: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111.
  - `bus_wdata`: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- BUS:
  - `bus_req`=1; address, data and enable registers are held stable.
  - Timeout counter increments each cycle.
  - Exit priority: `bus_error` (fault=2), then `bus_ack` (capture read data, fault=0), then counter reaching TIMEOUT_CYCLES-1 (fault=3).
  - Any exit goes to RESP. `bus_req` drops in the same registered update.
- RESP:
  - `lsu_done`=1; `lsu_fault` and `lsu_rdata` are valid.
  - Go to IDLE unconditionally. A request is only accepted in IDLE.
- Read extraction:
  - Shift = `bus_rdata` >> (8·off).
  - Byte: bit 7 extends to bits 31..8. Half: bit 15 extends to bits 31..16. Extension is replaced by zeros when `lsu_unsigned`=1.
  - Word: passed through unchanged.
  - Stores and faulted accesses return `lsu_rdata`=0.
- `lsu_stall` (combinational) = (IDLE & `lsu_req`) | BUS. It is 0 in RESP.
- Counter: 16-bit, cleared on entry to BUS, saturating.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the counter to 0.
- Reset asserted mid-transaction drops `bus_req` immediately (asynchronous). The pending access is lost with no `lsu_done`.
- Minimum latency, legal access with same-cycle ack:
  - Cycle 0: IDLE accepts.
  - Cycle 1: BUS, ack seen.
  - Cycle 2: RESP with `lsu_done`.
  - `lsu_stall` is high in cycles 0–1.
- Misaligned access: cycle 0 accept, cycle 1 RESP. `bus_req` never rises.
- Unmapped address: `bus_error` is seen at the earliest in the 2nd BUS cycle, giving 4 cycles total.
- At least one cycle with `bus_req`=0 separates consecutive transactions (the RESP and IDLE cycles).
- `bus_ack` and `bus_error` are ignored outside BUS.

## Test plan
- Word load at 0x0000_1000, slave acks in its first cycle with 0xDEADBEEF -> `bus_be`=1111, `lsu_done` in cycle 2, `lsu_rdata`=0xDEADBEEF, fault 0.
- Signed byte load at 0x...03, `bus_rdata`=0x80123456 -> `bus_be`=1000, `lsu_rdata`=0xFFFFFF80. Same with `lsu_unsigned`=1 -> 0x00000080.
- Half store of 0x0000ABCD at 0x...02 -> `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, `bus_addr` low bits 00, fault 0.
- Word load at 0x...02, and separately size=11 -> `lsu_fault`=1 one cycle after accept; `bus_req` stays 0 throughout.
- Unmapped address with `bus_error` pulsed the cycle after `bus_req` rises -> `lsu_fault`=2, `bus_req` drops, `lsu_rdata`=0.
- TIMEOUT_CYCLES=8, slave never acks -> `bus_req` high exactly 8 cycles, then `lsu_fault`=3. Repeat with `rstn` pulsed low mid-BUS -> `bus_req`=0 immediately, no `lsu_done`, and the next request completes normally.

Source files
------------

// File: rtl/bus_lsu.sv
// Data-side load/store unit: turns one CPU memory instruction into one bus
// transaction with lane steering, load extension, alignment and bus fault reporting.
module bus_lsu #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [1:0]  lsu_size,
   input  logic        lsu_unsigned,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] lsu_rdata,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic [1:0]  lsu_fault,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_error
);

   // state | meaning
   // IDLE  | waiting for lsu_req; all outputs low
   // BUS   | bus_req high, waiting for ack / error / timeout
   // RESP  | lsu_done pulse with fault code and load data
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] F_OK      = 2'd0;
   localparam logic [1:0] F_ALIGN   = 2'd1;
   localparam logic [1:0] F_BUSERR  = 2'd2;
   localparam logic [1:0] F_TIMEOUT = 2'd3;

   localparam logic [15:0] CNT_TC = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [1:0]  off;
   logic [1:0]  size_q;
   logic        uns_q;

   logic        misaligned;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] shifted;
   logic [31:0] rdata_c;
   logic        bus_exit;

   always_comb begin
      misaligned = 1'b0;
      be_c       = 4'b1111;
      wdata_c    = lsu_wdata;
      unique case (lsu_size)
         SZ_BYTE: begin
            be_c    = 4'b0001 << lsu_addr[1:0];
            wdata_c = {4{lsu_wdata[7:0]}};
         end
         SZ_HALF: begin
            misaligned = lsu_addr[0];
            be_c       = 4'b0011 << lsu_addr[1:0];
            wdata_c    = {2{lsu_wdata[15:0]}};
         end
         SZ_WORD: misaligned = |lsu_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Word accesses are always aligned, so the shifted value equals bus_rdata there.
   always_comb begin
      shifted = bus_rdata >> {off, 3'b000};
      rdata_c = shifted;
      unique case (size_q)
         SZ_BYTE: rdata_c = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata_c = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: rdata_c = shifted;
      endcase
   end

   assign bus_exit  = bus_error | bus_ack | (cnt == CNT_TC);
   assign lsu_stall = ((state == IDLE) & lsu_req) | (state == BUS);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         off       <= 2'd0;
         size_q    <= 2'd0;
         uns_q     <= 1'b0;
         lsu_rdata <= 32'd0;
         lsu_done  <= 1'b0;
         lsu_fault <= F_OK;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               lsu_done  <= 1'b0;
               lsu_fault <= F_OK;
               lsu_rdata <= 32'd0;
               if (lsu_req) begin
                  if (misaligned) begin
                     lsu_done  <= 1'b1;
                     lsu_fault <= F_ALIGN;
                     state     <= RESP;
                  end else begin
                     bus_req   <= 1'b1;
                     bus_addr  <= {lsu_addr[31:2], 2'b00};
                     bus_we    <= lsu_we;
                     bus_be    <= be_c;
                     bus_wdata <= wdata_c;
                     off       <= lsu_addr[1:0];
                     size_q    <= lsu_size;
                     uns_q     <= lsu_unsigned;
                     cnt       <= 16'd0;
                     state     <= BUS;
                  end
               end
            end
            BUS: begin
               if (cnt != 16'hFFFF)
                  cnt <= cnt + 16'd1;
               if (bus_exit) begin
                  bus_req   <= 1'b0;
                  bus_addr  <= 32'd0;
                  bus_wdata <= 32'd0;
                  bus_we    <= 1'b0;
                  bus_be    <= 4'd0;
                  lsu_done  <= 1'b1;
                  state     <= RESP;
                  if (bus_error) begin
                     lsu_fault <= F_BUSERR;
                     lsu_rdata <= 32'd0;
                  end else if (bus_ack) begin
                     lsu_fault <= F_OK;
                     lsu_rdata <= bus_we ? 32'd0 : rdata_c;
                  end else begin
                     lsu_fault <= F_TIMEOUT;
                     lsu_rdata <= 32'd0;
                  end
               end
            end
            RESP: begin
               lsu_done  <= 1'b0;
               lsu_fault <= F_OK;
               lsu_rdata <= 32'd0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_lsu.sv
// Directed bench for bus_lsu with a short timeout so the abort path is reachable.
module tb_bus_lsu;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        lsu_req = 1'b0;
   logic        lsu_we = 1'b0;
   logic [1:0]  lsu_size = 2'b00;
   logic        lsu_unsigned = 1'b0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wdata = 32'd0;
   logic [31:0] lsu_rdata;
   logic        lsu_stall;
   logic        lsu_done;
   logic [1:0]  lsu_fault;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata = 32'd0;
   logic        bus_ack = 1'b0;
   logic        bus_error = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   bus_lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rstn(rstn),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
      .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
      .lsu_fault(lsu_fault), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      lsu_req      = 1'b1;
      lsu_we       = we;
      lsu_size     = size;
      lsu_unsigned = uns;
      lsu_addr     = addr;
      lsu_wdata    = wdata;
   endtask

   task automatic release_req();
      lsu_req   = 1'b0;
      bus_ack   = 1'b0;
      bus_error = 1'b0;
      bus_rdata = 32'd0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      n_total++;
      if ({bus_req, lsu_done, lsu_stall, lsu_fault, bus_be, bus_we} !== 10'd0 ||
          lsu_rdata !== 32'd0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0)
         $display("FAIL reset_outputs: req=%b done=%b stall=%b fault=%0d be=%b rdata=%h addr=%h wdata=%h, all must be 0",
                  bus_req, lsu_done, lsu_stall, lsu_fault, bus_be, lsu_rdata, bus_addr, bus_wdata);
      else n_pass++;
      #3 rstn = 1'b1;
      tick();
      tick();
      n_total++;
      if ({bus_req, lsu_done, lsu_stall} !== 3'b000)
         $display("FAIL idle_outputs: req=%b done=%b stall=%b, required 000", bus_req, lsu_done, lsu_stall);
      else n_pass++;
   endtask

   task automatic test_word_load();
      issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0);
      #1;
      n_total++;
      if (lsu_stall !== 1'b1) $display("FAIL word_stall_c0: got %b want 1", lsu_stall);
      else n_pass++;
      tick();
      n_total++;
      if (bus_req !== 1'b1 || bus_be !== 4'b1111 || bus_addr !== 32'h0000_1000 || bus_we !== 1'b0 || lsu_stall !== 1'b1)
         $display("FAIL word_bus_c1: req=%b be=%b addr=%h we=%b stall=%b, want 1 1111 00001000 0 1",
                  bus_req, bus_be, bus_addr, bus_we, lsu_stall);
      else n_pass++;
      bus_ack   = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_rdata !== 32'hDEAD_BEEF || lsu_fault !== 2'd0 || bus_req !== 1'b0 || lsu_stall !== 1'b0)
         $display("FAIL word_resp_c2: done=%b rdata=%h fault=%0d req=%b stall=%b, want 1 deadbeef 0 0 0",
                  lsu_done, lsu_rdata, lsu_fault, bus_req, lsu_stall);
      else n_pass++;
      tick();
      n_total++;
      if (lsu_done !== 1'b0 || lsu_rdata !== 32'd0) $display("FAIL word_done_pulse: done=%b rdata=%h, want 0 0", lsu_done, lsu_rdata);
      else n_pass++;
   endtask

   task automatic test_byte_load(input logic uns, input logic [31:0] expv);
      issue(1'b0, 2'b00, uns, 32'h0000_2003, 32'd0);
      tick();
      n_total++;
      if (bus_be !== 4'b1000 || bus_addr !== 32'h0000_2000)
         $display("FAIL byte_be_uns%0d: be=%b addr=%h, want 1000 00002000", uns, bus_be, bus_addr);
      else n_pass++;
      bus_ack   = 1'b1;
      bus_rdata = 32'h8012_3456;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_rdata !== expv || lsu_fault !== 2'd0)
         $display("FAIL byte_rdata_uns%0d: done=%b rdata=%h fault=%0d, want 1 %h 0", uns, lsu_done, lsu_rdata, lsu_fault, expv);
      else n_pass++;
      tick();
   endtask

   task automatic test_half_store();
      issue(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD);
      tick();
      n_total++;
      if (bus_be !== 4'b1100 || bus_wdata !== 32'hABCD_ABCD || bus_we !== 1'b1 || bus_addr !== 32'h0000_3000 || bus_req !== 1'b1)
         $display("FAIL half_store_bus: be=%b wdata=%h we=%b addr=%h req=%b, want 1100 abcdabcd 1 00003000 1",
                  bus_be, bus_wdata, bus_we, bus_addr, bus_req);
      else n_pass++;
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_fault !== 2'd0 || lsu_rdata !== 32'd0)
         $display("FAIL half_store_resp: done=%b fault=%0d rdata=%h, want 1 0 0", lsu_done, lsu_fault, lsu_rdata);
      else n_pass++;
      tick();
   endtask

   task automatic test_misaligned(input logic [1:0] size, input logic [31:0] addr);
      logic saw_req;
      issue(1'b0, size, 1'b0, addr, 32'd0);
      bus_ack = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      saw_req = 1'b0;
      tick();
      saw_req = bus_req;
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_fault !== 2'd1 || lsu_rdata !== 32'd0)
         $display("FAIL misalign_sz%0d: done=%b fault=%0d rdata=%h, want 1 1 0", size, lsu_done, lsu_fault, lsu_rdata);
      else n_pass++;
      tick();
      saw_req = saw_req | bus_req;
      n_total++;
      if (saw_req !== 1'b0 || lsu_done !== 1'b0)
         $display("FAIL misalign_noreq_sz%0d: req_seen=%b done=%b, want 0 0", size, saw_req, lsu_done);
      else n_pass++;
   endtask

   task automatic test_bus_error();
      issue(1'b0, 2'b10, 1'b0, 32'hF000_0000, 32'd0);
      tick();
      bus_rdata = 32'h5555_AAAA;
      tick();
      n_total++;
      if (bus_req !== 1'b1 || lsu_done !== 1'b0) $display("FAIL buserr_wait: req=%b done=%b, want 1 0", bus_req, lsu_done);
      else n_pass++;
      bus_error = 1'b1;
      bus_ack   = 1'b1;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_fault !== 2'd2 || bus_req !== 1'b0 || lsu_rdata !== 32'd0)
         $display("FAIL buserr_resp: done=%b fault=%0d req=%b rdata=%h, want 1 2 0 0", lsu_done, lsu_fault, bus_req, lsu_rdata);
      else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      int req_cycles;
      logic got_done;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'd0);
      req_cycles = 0;
      got_done = 1'b0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         tick();
         if (bus_req) req_cycles++;
         if (lsu_done) got_done = 1'b1;
      end
      release_req();
      n_total++;
      if (!got_done || req_cycles != 8 || lsu_fault !== 2'd3)
         $display("FAIL timeout: done_seen=%b req_cycles=%0d fault=%0d, want 1 8 3", got_done, req_cycles, lsu_fault);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_bus();
      logic done_seen;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'd0);
      tick();
      tick();
      tick();
      #3 rstn = 1'b0;
      #1;
      n_total++;
      if (bus_req !== 1'b0 || lsu_done !== 1'b0) $display("FAIL rst_mid_bus: req=%b done=%b, want 0 0", bus_req, lsu_done);
      else n_pass++;
      release_req();
      #2 rstn = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         done_seen = done_seen | lsu_done | bus_req;
      end
      n_total++;
      if (done_seen !== 1'b0) $display("FAIL rst_lost_access: done_or_req_seen=%b, want 0", done_seen);
      else n_pass++;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'd0);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_fault !== 2'd0 || lsu_rdata !== 32'h0BAD_F00D)
         $display("FAIL rst_recover: done=%b fault=%0d rdata=%h, want 1 0 0badf00d", lsu_done, lsu_fault, lsu_rdata);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 2'b00, 1'b0, 32'h0000_6001, 32'd0);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h0000_AB00;
      tick();
      bus_ack = 1'b0;
      issue(1'b0, 2'b01, 1'b1, 32'h0000_6002, 32'd0);
      n_total++;
      if (lsu_done !== 1'b1 || lsu_rdata !== 32'hFFFF_FFAB || bus_req !== 1'b0 || lsu_stall !== 1'b0)
         $display("FAIL b2b_first: done=%b rdata=%h req=%b stall=%b, want 1 ffffffab 0 0", lsu_done, lsu_rdata, bus_req, lsu_stall);
      else n_pass++;
      tick();
      n_total++;
      if (bus_req !== 1'b0 || lsu_stall !== 1'b1 || lsu_done !== 1'b0)
         $display("FAIL b2b_gap: req=%b stall=%b done=%b, want 0 1 0", bus_req, lsu_stall, lsu_done);
      else n_pass++;
      tick();
      n_total++;
      if (bus_req !== 1'b1 || bus_be !== 4'b1100) $display("FAIL b2b_second_bus: req=%b be=%b, want 1 1100", bus_req, bus_be);
      else n_pass++;
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'hF00D_0000;
      tick();
      release_req();
      n_total++;
      if (lsu_done !== 1'b1 || lsu_rdata !== 32'h0000_F00D || lsu_fault !== 2'd0)
         $display("FAIL b2b_second_resp: done=%b rdata=%h fault=%0d, want 1 0000f00d 0", lsu_done, lsu_rdata, lsu_fault);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load(1'b0, 32'hFFFF_FF80);
      test_byte_load(1'b1, 32'h0000_0080);
      test_half_store();
      test_misaligned(2'b10, 32'h0000_4002);
      test_misaligned(2'b11, 32'h0000_5000);
      test_bus_error();
      test_timeout();
      test_reset_mid_bus();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
      $fatal(1);
   end

endmodule
